// File: rtl/seq_det_ctrl.sv
// Sequencing controller for the serial pattern detector: programmable target/quota,
// fill of the shift window, overlapping match counting and run completion.
module seq_det_ctrl #(
  parameter int               W       = 4,
  parameter int               CNT_W   = 8,
  parameter logic [W-1:0]     DEF_PAT = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  input  logic             data,
  input  logic             data_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             cfg_ready
);

  localparam int FW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W-2:0]     sh_q, sh_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] quota_q, quota_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [W-1:0]     window;
  logic [CNT_W-1:0] cnt_inc;

  assign window  = {sh_q, data};
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      quota_q <= CNT_W'(1);
      cnt_q   <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      quota_q <= quota_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    quota_d = quota_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          pat_d   = cfg_pattern;
          // A zero quota would never complete, so it is treated as one.
          quota_d = (cfg_count == '0) ? CNT_W'(1) : cfg_count;
        end else begin
          pat_d   = pat_q;
        end
        if (start) begin
          state_d = FILL;
          sh_d    = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (data_valid) begin
          sh_d   = window[W-2:0];
          fill_d = fill_q + FW'(1);
          if (fill_q == FW'(W - 2)) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        // Abort wins over a match landing in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (data_valid) begin
          sh_d = window[W-2:0];
          if (window == pat_q) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc == quota_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d  = (state_d == FILL) || (state_d == RUN);
  assign ready_d = (state_d == IDLE);

  assign busy      = busy_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign cfg_ready = ready_q;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Controller for the serial pattern-detector datapath (shift-in window compared against a target word). It holds a run-time programmable target pattern and match quota, and sequences fill, detection and completion of a detection run. It qualifies input bits with a valid strobe, counts overlapping matches and signals completion. Software-facing config/start/abort interface sits above; serial data source sits below.

Parameters:
W, 4, pattern width in bits (≥2)
CNT_W, 8, width of match quota and match counter
DEF_PAT, 4'b1101, pattern loaded at reset (W bits)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  load cfg_pattern/cfg_count this cycle
cfg_pattern  input  W  target pattern, MSB = oldest bit
cfg_count  input  CNT_W  matches required to finish a run
start  input  1  begin a detection run
abort  input  1  cancel the active run
data  input  1  serial input bit
data_valid  input  1  data qualifier
busy  output  1  high in FILL or RUN
match  output  1  one-cycle pulse per detected pattern
match_cnt  output  CNT_W  matches in current/last run
done  output  1  one-cycle pulse when quota reached
cfg_ready  output  1  high in IDLE (config accepted)

Behaviour:
- Reset (async, rst=1): state IDLE; shift reg 0; fill_cnt 0; pattern=DEF_PAT; quota=1; match=0, done=0, match_cnt=0, busy=0, cfg_ready=1.
- All outputs registered; busy = (state==FILL||RUN), cfg_ready = (state==IDLE), both registered with state.
- States: IDLE, FILL, RUN, DONE.
- IDLE: cfg_valid -> latch pattern and quota; cfg_count==0 is stored as 1. start -> FILL next cycle; clear shift reg, fill_cnt, match_cnt. cfg_valid and start in same cycle: config latched and the run uses the new values.
- cfg_valid outside IDLE: ignored. start outside IDLE: ignored.
- FILL: each data_valid cycle, shift reg <= {sh[W-2:0], data}, fill_cnt++. On the data_valid cycle where fill_cnt==W-2, go to RUN (W-1 bits held). No compares in FILL.
- RUN: each data_valid cycle, window = {sh[W-2:0], data}; shift reg <= window. If window==pattern: match=1 next cycle, match_cnt+1 next cycle. Overlapping matches count (1101101 with 1101 -> 2 matches).
- When match_cnt+1 == quota on a match: go to DONE; match and done assert together in that cycle.
- DONE: one cycle, then IDLE. match_cnt holds until next start.
- data_valid=0: no shift, no compare, no state change; gaps of any length allowed.
- abort in FILL or RUN: IDLE next cycle; no done, no match that cycle even if window matches. match_cnt holds. abort in IDLE/DONE: ignored. abort beats a coinciding match.
- match_cnt never exceeds quota; no wrap.
- Async reset mid-run: immediate return to reset values, including pattern=DEF_PAT and quota=1.
- Latency: bit completing pattern sampled at edge N -> match (and done, if applicable) high after edge N, for one cycle.

Test Plan:
- Reset defaults, start, stream 1,1,0,1 with data_valid=1 -> busy high from cycle after start; match and done pulse together after 4th bit; match_cnt=1; IDLE with cfg_ready=1 next cycle.
- cfg_count=2, stream 1,1,0,1,1,0,1 -> match after bits 4 and 7; done with 2nd match; match_cnt=2 (overlap counted).
- cfg_pattern=0110, cfg_count=3, valid bits 0,1,1,0,1,1,0,1,1,0 with data_valid low on alternate cycles -> 3 matches, done on 3rd; gap cycles cause no shift or compare.
- cfg_count=0 -> behaves as quota 1; cfg_valid while busy -> pattern unchanged (verify via subsequent run).
- Quota 5, abort after 2 matches, abort coinciding with a matching bit -> IDLE next cycle, no match/done, match_cnt=2.
- rst pulse mid-RUN, asynchronous to clk -> outputs zero immediately; next run detects 1101 with quota 1.
